// File: rtl/led_breath_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_breath_pwm_pkg
// Brief    : Mode and breathing-direction encodings shared by the LED PWM block.
// Revision : 1.0 - initial release
// ============================================================================
package led_breath_pwm_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_FIXED   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic logic mode_uses_duty(input mode_e mode);
        return (mode == MODE_FIXED) || (mode == MODE_BREATHE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_breath_channel.sv
`default_nettype none
// ============================================================================
// Module   : led_breath_channel
// Brief    : One PWM channel: mode/level/direction state, triangle stepping,
//            optional gamma (LED_BREATH_PWM_GAMMA_EN) and registered compare.
// Revision : 1.0 - initial release
// ============================================================================
module led_breath_channel
    import led_breath_pwm_pkg::*;
#(
    parameter int PWM_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 commit,
    input  logic [MODE_W-1:0]    cfg_mode,
    input  logic [PWM_WIDTH-1:0] cfg_level,
    input  logic                 step_tick,
    input  logic [PWM_WIDTH-1:0] counter,
    output logic                 pwm_out
);

    localparam logic [PWM_WIDTH-1:0] c_LEVEL_MAX = {PWM_WIDTH{1'b1}};
    localparam logic [PWM_WIDTH-1:0] c_LEVEL_ONE = PWM_WIDTH'(1);

    mode_e                r_mode;
    dir_e                 r_dir;
    logic [PWM_WIDTH-1:0] r_level;
    logic                 r_pwm;
    logic [PWM_WIDTH-1:0] w_step_level;
    dir_e                 w_step_dir;
    logic [PWM_WIDTH-1:0] w_duty;
    mode_e                w_cfg_mode;

    assign w_cfg_mode = mode_e'(cfg_mode);

    // Each endpoint is emitted exactly once, then the direction flips.
    always_comb begin
        w_step_level = r_level;
        w_step_dir   = r_dir;
        if (r_dir == DIR_UP) begin
            if (r_level == c_LEVEL_MAX) begin
                w_step_dir   = DIR_DOWN;
                w_step_level = c_LEVEL_MAX - c_LEVEL_ONE;
            end else begin
                w_step_level = r_level + c_LEVEL_ONE;
            end
        end else begin
            if (r_level == '0) begin
                w_step_dir   = DIR_UP;
                w_step_level = c_LEVEL_ONE;
            end else begin
                w_step_level = r_level - c_LEVEL_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mode  <= MODE_OFF;
            r_level <= '0;
            r_dir   <= DIR_UP;
        end else if (commit) begin
            r_mode <= w_cfg_mode;
            case (w_cfg_mode)
                MODE_BREATHE: begin
                    r_level <= cfg_level;
                    r_dir   <= DIR_UP;
                end
                MODE_FIXED: r_level <= cfg_level;
                default: ;
            endcase
        end else if (step_tick && (r_mode == MODE_BREATHE)) begin
            r_level <= w_step_level;
            r_dir   <= w_step_dir;
        end
    end

`ifdef LED_BREATH_PWM_GAMMA_EN
    logic [2*PWM_WIDTH-1:0] w_square;
    logic [PWM_WIDTH-1:0]   r_duty;

    assign w_square = r_level * r_level;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_duty <= '0;
        end else begin
            r_duty <= w_square[2*PWM_WIDTH-1:PWM_WIDTH];
        end
    end

    assign w_duty = r_duty;
`else
    assign w_duty = r_level;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pwm <= 1'b0;
        end else if (mode_uses_duty(r_mode)) begin
            r_pwm <= (counter < w_duty);
        end else begin
            r_pwm <= (r_mode == MODE_ON);
        end
    end

    assign pwm_out = r_pwm;

endmodule
`default_nettype wire

// File: rtl/led_breath_pwm.sv
`default_nettype none
// ============================================================================
// Module   : led_breath_pwm
// Brief    : Multi-channel LED PWM with off/on/fixed/breathing modes and a
//            period-aligned config commit. Gamma option: LED_BREATH_PWM_GAMMA_EN.
// Revision : 1.0 - initial release
// ============================================================================
module led_breath_pwm
    import led_breath_pwm_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int PWM_WIDTH = 10,
    parameter int STEP_DIV  = 65536,
    parameter int CH_IDX_W  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_IDX_W-1:0]  cfg_channel,
    input  logic [MODE_W-1:0]    cfg_mode,
    input  logic [PWM_WIDTH-1:0] cfg_level,
    output logic                 period_start,
    output logic [CHANNELS-1:0]  pwm_out
);

    localparam int                   c_PRESC_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(STEP_DIV - 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_ONE  = c_PRESC_W'(1);
    localparam logic [PWM_WIDTH-1:0] c_CNT_LAST   = {PWM_WIDTH{1'b1}};
    localparam logic [PWM_WIDTH-1:0] c_CNT_ONE    = PWM_WIDTH'(1);

    logic [PWM_WIDTH-1:0] r_counter;
    logic [c_PRESC_W-1:0] r_presc;
    logic                 r_period_start;
    logic                 r_ready;
    logic                 r_held;
    logic [CH_IDX_W-1:0]  r_hold_channel;
    logic [MODE_W-1:0]    r_hold_mode;
    logic [PWM_WIDTH-1:0] r_hold_level;

    logic                 w_accept;
    logic                 w_commit;
    logic                 w_tick;
    logic [CHANNELS-1:0]  w_ch_commit;

    assign w_accept = cfg_valid && r_ready;
    assign w_commit = r_held && (r_counter == c_CNT_LAST);
    assign w_tick   = (r_presc == c_PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_counter      <= '0;
            r_presc        <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_counter      <= r_counter + c_CNT_ONE;
            r_period_start <= (r_counter == c_CNT_LAST);
            if (w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + c_PRESC_ONE;
            end
        end
    end

    // Ready is simply "holder empty" except for the reset cycle itself, so a
    // transfer can never land in the same cycle as a commit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_held         <= 1'b0;
            r_ready        <= 1'b0;
            r_hold_channel <= '0;
            r_hold_mode    <= '0;
            r_hold_level   <= '0;
        end else if (w_accept) begin
            r_held         <= 1'b1;
            r_ready        <= 1'b0;
            r_hold_channel <= cfg_channel;
            r_hold_mode    <= cfg_mode;
            r_hold_level   <= cfg_level;
        end else if (w_commit) begin
            r_held  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_ready <= !r_held;
        end
    end

    assign cfg_ready    = r_ready;
    assign period_start = r_period_start;

    // Out-of-range channel indices match no instance and are dropped.
    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_channel
            localparam logic [CH_IDX_W-1:0] c_IDX = CH_IDX_W'(g);

            assign w_ch_commit[g] = w_commit && (r_hold_channel == c_IDX);

            led_breath_channel #(
                .PWM_WIDTH (PWM_WIDTH)
            ) u_channel (
                .clk       (clk),
                .reset_n   (reset_n),
                .commit    (w_ch_commit[g]),
                .cfg_mode  (r_hold_mode),
                .cfg_level (r_hold_level),
                .step_tick (w_tick),
                .counter   (r_counter),
                .pwm_out   (pwm_out[g])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_led_breath_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_breath_pwm
// Brief    : Self-checking bench for led_breath_pwm (W=4, 2 channels, DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_breath_pwm;

    localparam int W    = 4;
    localparam int CH   = 2;
    localparam int DIV  = 4;
    localparam int IW   = 2;
    localparam int MAXL = (1 << W) - 1;
    localparam int PER  = 1 << W;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [IW-1:0] cfg_channel;
    logic [1:0]    cfg_mode;
    logic [W-1:0]  cfg_level;
    logic          period_start;
    logic [CH-1:0] pwm_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    led_breath_pwm #(
        .CHANNELS  (CH),
        .PWM_WIDTH (W),
        .STEP_DIV  (DIV),
        .CH_IDX_W  (IW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_channel  (cfg_channel),
        .cfg_mode     (cfg_mode),
        .cfg_level    (cfg_level),
        .period_start (period_start),
        .pwm_out      (pwm_out)
    );

    // Model: edge count since reset drives everything; a breathing level is a
    // closed-form position on a 2*MAX triangle, counted in ticks since commit.
    bit            m_live = 1'b0;
    int            m_j;
    int            m_c;
    bit            m_held;
    bit            m_ready;
    int            h_ch, h_mode, h_lvl;
    int            ch_mode  [CH];
    int            ch_lvl   [CH];
    int            ch_start [CH];
    int            ch_jc    [CH];
    logic [CH-1:0] exp_pwm;
    logic          exp_ps;

    function automatic int tri_level(input int start, input int n);
        int ph;
        ph = (start + n) % (2 * MAXL);
        return (ph <= MAXL) ? ph : (2 * MAXL - ph);
    endfunction

    function automatic int level_at(input int k, input int e);
        if (ch_mode[k] == 3) return tri_level(ch_start[k], e / DIV - ch_jc[k] / DIV);
        return ch_lvl[k];
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_live  = 1'b1;
            m_j     = 0;
            m_held  = 1'b0;
            m_ready = 1'b0;
            exp_pwm = '0;
            exp_ps  = 1'b0;
            for (int k = 0; k < CH; k++) begin
                ch_mode[k] = 0; ch_lvl[k] = 0; ch_start[k] = 0; ch_jc[k] = 0;
            end
        end else if (m_live) begin
            m_c = m_j % PER;
            for (int k = 0; k < CH; k++) begin
                if (ch_mode[k] == 0)      exp_pwm[k] = 1'b0;
                else if (ch_mode[k] == 1) exp_pwm[k] = 1'b1;
                else                      exp_pwm[k] = (m_c < level_at(k, m_j));
            end
            if (m_held && (m_c == PER - 1)) begin
                if (h_ch < CH) begin
                    if (h_mode == 3) begin
                        ch_start[h_ch] = h_lvl;
                        ch_jc[h_ch]    = m_j + 1;
                    end else if (h_mode == 2) begin
                        ch_lvl[h_ch] = h_lvl;
                    end else begin
                        ch_lvl[h_ch] = level_at(h_ch, m_j);
                    end
                    ch_mode[h_ch] = h_mode;
                end
                m_held = 1'b0;
            end
            if (cfg_valid && m_ready) begin
                m_held = 1'b1;
                h_ch   = int'(cfg_channel);
                h_mode = int'(cfg_mode);
                h_lvl  = int'(cfg_level);
            end
            m_j++;
            exp_ps  = ((m_j % PER) == 0);
            m_ready = !m_held;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("cyc_pwm_out", int'(pwm_out), int'(exp_pwm));
                chk("cyc_period_start", int'(period_start), int'(exp_ps));
                chk("cyc_cfg_ready", int'(cfg_ready), int'(m_ready));
            end
        end
    endtask

    task automatic cfg_write(input int ch, input int mode, input int lvl, output bit ps_at_accept);
        int n;
        n = 0;
        @(posedge clk); #1;
        cfg_channel = IW'(ch);
        cfg_mode    = 2'(mode);
        cfg_level   = W'(lvl);
        cfg_valid   = 1'b1;
        @(negedge clk);
        while (!cfg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cfg_accept_in_time", int'(cfg_ready), 1);
        ps_at_accept = period_start;
        @(posedge clk); #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!cfg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(cfg_ready), 1);
    endtask

    task automatic wait_ps(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 100);
        chk(name, int'(period_start), 1);
    endtask

    task automatic count_period(input int ch, output int cnt, output int shape);
        cnt   = 0;
        shape = 0;
        for (int k = 0; k < PER; k++) begin
            @(negedge clk);
            if (pwm_out[ch]) begin
                cnt++;
                shape |= (1 << k);
            end
        end
    endtask

    initial begin
        bit ps;
        int cnt, shape, gap, hits15, hits0;

        reset_n     = 1'b0;
        cfg_valid   = 1'b0;
        cfg_channel = '0;
        cfg_mode    = '0;
        cfg_level   = '0;
        fork
            compare_loop();
        join_none

        // Model self-pins: triangle from 14 going up.
        chk("model_tri_n0", tri_level(14, 0), 14);
        chk("model_tri_n1", tri_level(14, 1), 15);
        chk("model_tri_n2", tri_level(14, 2), 14);
        chk("model_tri_n16", tri_level(14, 16), 0);
        chk("model_tri_n17", tri_level(14, 17), 1);
        hits15 = 0;
        hits0  = 0;
        for (int n = 0; n < 2 * MAXL; n++) begin
            if (tri_level(14, n) == MAXL) hits15++;
            if (tri_level(14, n) == 0) hits0++;
        end
        chk("model_max_once", hits15, 1);
        chk("model_zero_once", hits0, 1);

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("release_ready", int'(cfg_ready), 1);
        chk("release_pwm", int'(pwm_out), 0);

        wait_ps("first_period_start");
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!period_start && gap < 40);
        chk("period_start_interval", gap, PER);

        // Fixed duty 5 on ch0, issued mid-period.
        repeat (5) @(negedge clk);
        cfg_write(0, 2, 5, ps);
        cfg_valid = 1'b0;
        chk("ready_low_after_accept", int'(cfg_ready), 0);
        wait_ready("fixed5_commit");
        chk("fixed5_commit_at_boundary", int'(period_start), 1);
        count_period(0, cnt, shape);
        chk("fixed5_high_count", cnt, 5);
        chk("fixed5_shape", shape, 'h001F);

        // Breathe on ch1 from 14: levels 14,15,14,13 across the first period.
        cfg_write(1, 3, 14, ps);
        cfg_valid = 1'b0;
        wait_ready("breathe_commit");
        count_period(1, cnt, shape);
        chk("breathe_first_shape", shape, 'h1FFF);
        repeat (2 * MAXL * DIV + 10) @(negedge clk);

        // Back-to-back with valid held: second lands one period later.
        cfg_write(0, 1, 0, ps);
        cfg_write(0, 2, 10, ps);
        chk("b2b_second_at_boundary", int'(ps), 1);
        cfg_valid = 1'b0;
        count_period(0, cnt, shape);
        chk("b2b_on_count", cnt, PER);
        count_period(0, cnt, shape);
        chk("b2b_fixed10_shape", shape, 'h03FF);

        // Out-of-range channel: handshake completes, nothing changes.
        cfg_write(3, 1, 0, ps);
        cfg_valid = 1'b0;
        wait_ready("bad_channel_handshake");
        count_period(0, cnt, shape);
        chk("bad_channel_ch0_kept", shape, 'h03FF);

        // Reset while an entry is held: the entry must be dropped.
        cfg_write(0, 2, 7, ps);
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("held_before_reset", int'(cfg_ready), 0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_ready", int'(cfg_ready), 0);
        chk("reset_period_start", int'(period_start), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rerelease_ready", int'(cfg_ready), 1);
        wait_ps("post_reset_period");
        wait_ps("post_reset_period2");
        count_period(0, cnt, shape);
        chk("post_reset_ch0_off", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
